// File: rtl/even_odd_seq_monitor_if.sv
// Stream bus between an even/odd counter source and its sequence monitor.
// The source drives samples; the monitor returns lock and error status.
interface even_odd_seq_monitor_if #(
    parameter int W     = 3,
    parameter int ERR_W = 8
);
    logic             in_en;
    logic [W-1:0]     q_in;
    logic             locked;
    logic             odd_mode;
    logic             err;
    logic             parity_flip;
    logic [ERR_W-1:0] err_count;

    modport master (
        output in_en, q_in,
        input  locked, odd_mode, err, parity_flip, err_count
    );

    modport slave (
        input  in_en, q_in,
        output locked, odd_mode, err, parity_flip, err_count
    );
endinterface

// File: rtl/even_odd_seq_monitor.sv
// Locks onto an even or odd +2 count stream and flags broken steps.
// Errors are only counted once lock has been established.
module even_odd_seq_monitor #(
    parameter int W      = 3,
    parameter int LOCK_N = 2,
    parameter int ERR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    even_odd_seq_monitor_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     last_q, last_d;
    logic [3:0]       run_q, run_d;
    logic             locked_q, locked_d;
    logic             odd_q, odd_d;
    logic             err_q, err_d;
    logic             pflip_q, pflip_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;

    logic [W-1:0]     next_exp;
    logic [3:0]       run_inc;
    logic             good;

    // Step arithmetic wraps naturally in W bits (6->0, 7->1 at W=3)
    assign next_exp = last_q + W'(2);
    assign good     = (bus.q_in == next_exp);
    assign run_inc  = run_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        run_d    = run_q;
        locked_d = locked_q;
        odd_d    = odd_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        pflip_d  = 1'b0;
        if (bus.in_en) begin
            unique case (state_q)
                IDLE: begin
                    last_d  = bus.q_in;
                    run_d   = 4'd0;
                    state_d = ACQ;
                end
                ACQ: begin
                    last_d = bus.q_in;
                    if (!good) begin
                        run_d = 4'd0;
                    end else if (run_inc == 4'(LOCK_N)) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                        odd_d    = bus.q_in[0];
                        run_d    = 4'd0;
                    end else begin
                        run_d = run_inc;
                    end
                end
                LOCKED: begin
                    last_d = bus.q_in;
                    if (!good) begin
                        err_d    = 1'b1;
                        pflip_d  = bus.q_in[0] ^ odd_q;
                        locked_d = 1'b0;
                        run_d    = 4'd0;
                        state_d  = ACQ;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + ERR_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= '0;
            run_q    <= '0;
            locked_q <= 1'b0;
            odd_q    <= 1'b0;
            err_q    <= 1'b0;
            pflip_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            run_q    <= run_d;
            locked_q <= locked_d;
            odd_q    <= odd_d;
            err_q    <= err_d;
            pflip_q  <= pflip_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.locked      = locked_q;
    assign bus.odd_mode    = odd_q;
    assign bus.err         = err_q;
    assign bus.parity_flip = pflip_q;
    assign bus.err_count   = cnt_q;
endmodule

// File: tb/tb_even_odd_seq_monitor.sv
// Bench for even_odd_seq_monitor: directed vector table, saturation run,
// and random stream checked against a segment-based reference model.
module tb_even_odd_seq_monitor;
    localparam int W      = 3;
    localparam int LOCK_N = 2;
    localparam int MODV   = 1 << W;

    logic         clk;
    logic         rst;
    logic         en;
    logic [W-1:0] qv;

    int checks;
    int errors;

    even_odd_seq_monitor_if #(.W(W), .ERR_W(8)) bus8 ();
    even_odd_seq_monitor_if #(.W(W), .ERR_W(2)) bus2 ();

    assign bus8.in_en = en;
    assign bus8.q_in  = qv;
    assign bus2.in_en = en;
    assign bus2.q_in  = qv;

    even_odd_seq_monitor #(.W(W), .LOCK_N(LOCK_N), .ERR_W(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    even_odd_seq_monitor #(.W(W), .LOCK_N(LOCK_N), .ERR_W(2)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: current run of consecutive good samples.
    // Locked whenever that run holds more than LOCK_N samples.
    int seg[$];
    bit m_odd;
    int m_cnt;
    bit m_err;
    bit m_pf;

    function automatic void model(bit r, bit e, int q);
        m_err = 0;
        m_pf  = 0;
        if (r) begin
            seg.delete();
            m_odd = 0;
            m_cnt = 0;
            return;
        end
        if (!e) return;
        if (seg.size() == 0) begin
            seg.push_back(q);
            return;
        end
        if (q == (seg[$] + 2) % MODV) begin
            seg.push_back(q);
            if (seg.size() == LOCK_N + 1) m_odd = bit'(q % 2);
            if (seg.size() > LOCK_N + 1) void'(seg.pop_front());
        end else begin
            if (seg.size() > LOCK_N) begin
                m_err = 1;
                m_cnt++;
                m_pf = ((q % 2) != int'(m_odd));
            end
            seg.delete();
            seg.push_back(q);
        end
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(string tag, int l, int o, int er, int pf, int c);
        int cs;
        cs = (c > 3) ? 3 : c;
        chk({tag, " locked"},    32'(bus8.locked),      32'(l));
        chk({tag, " odd_mode"},  32'(bus8.odd_mode),    32'(o));
        chk({tag, " err"},       32'(bus8.err),         32'(er));
        chk({tag, " pflip"},     32'(bus8.parity_flip), 32'(pf));
        chk({tag, " err_count"}, 32'(bus8.err_count),   32'(c));
        chk({tag, " sat locked"}, 32'(bus2.locked),     32'(l));
        chk({tag, " sat err"},   32'(bus2.err),         32'(er));
        chk({tag, " sat count"}, 32'(bus2.err_count),   32'(cs));
    endtask

    task automatic step(bit r, bit e, int q);
        rst = r;
        en  = e;
        qv  = W'(q);
        model(r, e, q);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit r;
        bit e;
        int q;
        int l;
        int o;
        int er;
        int pf;
        int c;
    } vec_t;

    vec_t tv[$];

    function automatic void v(bit r, bit e, int q,
                              int l, int o, int er, int pf, int c);
        vec_t t;
        t.r  = r;
        t.e  = e;
        t.q  = q;
        t.l  = l;
        t.o  = o;
        t.er = er;
        t.pf = pf;
        t.c  = c;
        tv.push_back(t);
    endfunction

    initial begin
        int prev;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        en  = 1'b0;
        qv  = '0;

        // reset, even stream with 6->0 wrap
        v(1, 0, 0, 0, 0, 0, 0, 0);
        v(0, 1, 0, 0, 0, 0, 0, 0);
        v(0, 1, 2, 0, 0, 0, 0, 0);
        v(0, 1, 4, 1, 0, 0, 0, 0);
        v(0, 1, 6, 1, 0, 0, 0, 0);
        v(0, 1, 0, 1, 0, 0, 0, 0);
        v(0, 1, 2, 1, 0, 0, 0, 0);
        // reset wins over in_en; odd stream with 7->1 wrap
        v(1, 1, 5, 0, 0, 0, 0, 0);
        v(0, 1, 1, 0, 0, 0, 0, 0);
        v(0, 1, 3, 0, 0, 0, 0, 0);
        v(0, 1, 5, 1, 1, 0, 0, 0);
        v(0, 1, 7, 1, 1, 0, 0, 0);
        v(0, 1, 1, 1, 1, 0, 0, 0);
        // even lock, parity change, relock odd
        v(1, 0, 0, 0, 0, 0, 0, 0);
        v(0, 1, 0, 0, 0, 0, 0, 0);
        v(0, 1, 2, 0, 0, 0, 0, 0);
        v(0, 1, 4, 1, 0, 0, 0, 0);
        v(0, 1, 1, 0, 0, 1, 1, 1);
        v(0, 1, 3, 0, 0, 0, 0, 1);
        v(0, 1, 5, 1, 1, 0, 0, 1);
        // repeated value, then idle gap holds everything
        v(1, 0, 0, 0, 0, 0, 0, 0);
        v(0, 1, 0, 0, 0, 0, 0, 0);
        v(0, 1, 2, 0, 0, 0, 0, 0);
        v(0, 1, 4, 1, 0, 0, 0, 0);
        v(0, 1, 4, 0, 0, 1, 0, 1);
        for (int i = 0; i < 5; i++) v(0, 0, 7, 0, 0, 0, 0, 1);
        v(0, 1, 6, 0, 0, 0, 0, 1);
        v(0, 1, 0, 1, 0, 0, 0, 1);
        // second error, relock odd, then mid-stream reset
        v(0, 1, 3, 0, 0, 1, 1, 2);
        v(0, 1, 5, 0, 0, 0, 0, 2);
        v(0, 1, 7, 1, 1, 0, 0, 2);
        v(1, 1, 2, 0, 0, 0, 0, 0);
        v(0, 1, 4, 0, 0, 0, 0, 0);
        v(0, 1, 6, 0, 0, 0, 0, 0);
        v(0, 1, 0, 1, 0, 0, 0, 0);

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].r, tv[i].e, tv[i].q);
            chk_all($sformatf("vec%0d", i),
                    tv[i].l, tv[i].o, tv[i].er, tv[i].pf, tv[i].c);
        end

        // five errors via repeated relock; 2-bit counter must stop at 3
        step(1, 1, 0);
        step(0, 1, 0);
        for (int k = 1; k <= 5; k++) begin
            step(0, 1, 2);
            step(0, 1, 4);
            chk($sformatf("sat%0d locked", k), 32'(bus2.locked), 32'd1);
            step(0, 1, 0);
            chk($sformatf("sat%0d err", k), 32'(bus2.err), 32'd1);
            chk($sformatf("sat%0d count", k), 32'(bus2.err_count),
                32'((k > 3) ? 3 : k));
            chk($sformatf("sat%0d wide", k), 32'(bus8.err_count), 32'(k));
        end

        // random stream, mostly good steps with occasional breaks
        step(1, 0, 0);
        prev = 0;
        for (int n = 0; n < 4000; n++) begin
            bit r;
            bit e;
            int q;
            r = ($urandom % 300) == 0;
            e = ($urandom % 4) != 0;
            if (($urandom % 6) == 0) q = int'($urandom % MODV);
            else q = (prev + 2) % MODV;
            if (e) prev = q;
            step(r, e, q);
            chk_all($sformatf("rnd%0d", n), int'(seg.size() > LOCK_N),
                    int'(m_odd), int'(m_err), int'(m_pf),
                    (m_cnt > 255) ? 255 : m_cnt);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/even_odd_seq_monitor.md
Name: even_odd_seq_monitor

Overview:
- Receive-side checker for the even/odd counter output stream.
- Samples a W-bit count value on each enabled cycle and determines whether the stream is a valid even sequence (0,2,4,6,0,...) or odd sequence (1,3,5,7,1,...).
- Locks onto the sequence, then flags every broken step and counts errors.
- Sits downstream of the counter in self-checking subsystems and in the bench's scoreboard path.

Parameters:
- W, 3, width of the observed count value; all step arithmetic is modulo 2^W.
- LOCK_N, 2, consecutive valid +2 steps needed to declare lock; legal range is 1 to 15.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_en  input  1  q_in is sampled on this cycle.
- q_in  input  W  observed count value.
- locked  output  1  high while in LOCKED state.
- odd_mode  output  1  parity of the locked sequence (1 = odd, 0 = even); valid only when locked=1.
- err  output  1  one-cycle pulse on a broken step while locked.
- parity_flip  output  1  one-cycle pulse when an error sample's parity differs from odd_mode.
- err_count  output  ERR_W  number of errors since reset; saturates at all-ones.

Behaviour:
- One clock; reset is synchronous and active-high; rst has priority over all other inputs.
- Reset values: locked=0, odd_mode=0, err=0, parity_flip=0, err_count=0. Internal state: state=IDLE, last=0, run=0.
- All outputs are registered. Effects of a sample at edge N are visible after edge N. Latency is 1 cycle.
- in_en=0: state, last, run, locked, odd_mode and err_count hold; err=0 and parity_flip=0.
- A "good step" means q_in == (last + 2) mod 2^W. Wrap cases at W=3: 6 -> 0 and 7 -> 1.
- A repeated value (q_in == last) is not a good step.
- State IDLE, on in_en: last <= q_in, run <= 0, go to ACQ.
- State ACQ, on in_en:
  - Good step: run <= run + 1, last <= q_in.
  - If run+1 == LOCK_N: go to LOCKED, locked <= 1, odd_mode <= q_in[0], run <= 0.
  - Bad step: run <= 0, last <= q_in, stay in ACQ. No err pulse and no err_count change.
- State LOCKED, on in_en:
  - Good step: last <= q_in, no other change.
  - Bad step: err <= 1 for one cycle; err_count increments (held at all-ones once saturated); locked <= 0; last <= q_in; run <= 0; go to ACQ.
  - On a bad step, parity_flip <= (q_in[0] != odd_mode).
- odd_mode holds its last locked value while unlocked. It is updated only on lock acquisition.
- A parity change from the counter therefore costs one err plus a relock of LOCK_N+1 samples.
- Reset mid-stream returns to IDLE. err_count clears. The first post-reset sample only seeds last.

Test Plan:
- Reset, then in_en=1 each cycle with q_in=0,2,4,6,0,2 -> locked=1 after the 3rd sample's edge, odd_mode=0, err=0 throughout, wrap 6->0 accepted.
- q_in=1,3,5,7,1 -> locked=1 after the 3rd sample, odd_mode=1, wrap 7->1 accepted, err_count=0.
- Locked even stream 0,2,4, then 1,3,5 -> after sample 1: err=1, parity_flip=1, locked=0, err_count=1. After 3,5: relocked with odd_mode=1.
- Locked stream 2,4,4 (repeat) -> err=1, parity_flip=0, locked=0, err_count=1. in_en low for 5 cycles mid-stream -> no state change, no pulses.
- ERR_W=2, force 5 errors (alternating relocks) -> err_count stops at 3, err still pulses on each error.
- Locked with err_count=2, assert rst for 1 cycle, then q_in=4,6,0 -> all outputs 0 after reset, locked=1 after the 0 sample, err_count=0.
